// File: rtl/sb_tx_msg_arbiter_if.sv
// Bundle of requester-side and serializer-side signals of the sideband TX arbiter.
// The master modport is the arbiter's view. The slave modport is the environment's view.
interface sb_tx_msg_arbiter_if #(
    parameter int SB_MSG_WIDTH = 4,
    parameter int NUM_REQ      = 4
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]              i_req_valid;
    logic [NUM_REQ*SB_MSG_WIDTH-1:0] i_req_msg;
    logic                            i_sb_busy;
    logic                            o_sb_valid;
    logic [SB_MSG_WIDTH-1:0]         o_sb_msg;
    logic [SRC_W-1:0]                o_sb_src;
    logic [NUM_REQ-1:0]              o_grant;
    logic [NUM_REQ-1:0]              o_done;
    logic                            o_timeout;

    modport master (
        input  i_req_valid, i_req_msg, i_sb_busy,
        output o_sb_valid, o_sb_msg, o_sb_src, o_grant, o_done, o_timeout
    );

    modport slave (
        output i_req_valid, i_req_msg, i_sb_busy,
        input  o_sb_valid, o_sb_msg, o_sb_src, o_grant, o_done, o_timeout
    );
endinterface

// File: rtl/sb_tx_msg_arbiter.sv
// Round-robin arbiter that serialises LTSM sideband message requests onto one serializer.
// Valid/busy handshake, an acceptance timeout and a one-cycle completion pulse go back to the winner.
module sb_tx_msg_arbiter #(
    parameter int SB_MSG_WIDTH = 4,
    parameter int NUM_REQ      = 4,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sb_tx_msg_arbiter_if.master   io_bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RELEASE   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [SRC_W-1:0]        r_ptr;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sb_valid;
    logic [SB_MSG_WIDTH-1:0] r_sb_msg;
    logic [SRC_W-1:0]        r_sb_src;
    logic [NUM_REQ-1:0]      r_grant;
    logic [NUM_REQ-1:0]      r_done;
    logic                    r_timeout;

    logic                    w_win_found;
    logic [SRC_W-1:0]        w_win_idx;
    logic [SB_MSG_WIDTH-1:0] w_win_msg;
    logic [SRC_W-1:0]        w_next_ptr;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [SRC_W-1:0] idx);
        logic [NUM_REQ-1:0] v_vec;
        v_vec      = '0;
        v_vec[idx] = 1'b1;
        return v_vec;
    endfunction

    // Winner search: scan offsets from highest to lowest so the closest set bit at/after r_ptr wins.
    always_comb begin
        logic [SRC_W:0] v_sum;
        logic [SRC_W:0] v_cand;
        v_sum       = '0;
        v_cand      = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            v_sum = {1'b0, r_ptr} + (SRC_W+1)'(i);
            if (v_sum >= (SRC_W+1)'(NUM_REQ)) begin
                v_cand = v_sum - (SRC_W+1)'(NUM_REQ);
            end else begin
                v_cand = v_sum;
            end
            if (io_bus.i_req_valid[v_cand[SRC_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = v_cand[SRC_W-1:0];
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    assign w_win_msg  = io_bus.i_req_msg[int'(w_win_idx)*SB_MSG_WIDTH +: SB_MSG_WIDTH];
    assign w_next_ptr = (r_sb_src == SRC_W'(NUM_REQ - 1)) ? SRC_W'(0) : r_sb_src + SRC_W'(1);

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_sb_valid <= 1'b0;
            r_sb_msg   <= '0;
            r_sb_src   <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A busy serializer is owned by someone else: never grant into it.
                    if (!io_bus.i_sb_busy && w_win_found) begin
                        r_state    <= ST_ISSUE;
                        r_sb_msg   <= w_win_msg;
                        r_sb_src   <= w_win_idx;
                        r_grant    <= f_onehot(w_win_idx);
                        r_sb_valid <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (io_bus.i_sb_busy) begin
                        r_state    <= ST_WAIT_DONE;
                        r_sb_valid <= 1'b0;
                    end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        r_state    <= ST_RELEASE;
                        r_sb_valid <= 1'b0;
                        r_grant    <= '0;
                        r_done     <= f_onehot(r_sb_src);
                        r_timeout  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!io_bus.i_sb_busy) begin
                        r_state <= ST_RELEASE;
                        r_grant <= '0;
                        r_done  <= f_onehot(r_sb_src);
                    end
                end
                ST_RELEASE: begin
                    // No arbitration here, so the winner's still-high valid cannot re-grant.
                    r_state   <= ST_IDLE;
                    r_done    <= '0;
                    r_timeout <= 1'b0;
                    r_ptr     <= w_next_ptr;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_sb_valid <= 1'b0;
                    r_grant    <= '0;
                    r_done     <= '0;
                    r_timeout  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.o_sb_valid = r_sb_valid;
    assign io_bus.o_sb_msg   = r_sb_msg;
    assign io_bus.o_sb_src   = r_sb_src;
    assign io_bus.o_grant    = r_grant;
    assign io_bus.o_done     = r_done;
    assign io_bus.o_timeout  = r_timeout;
endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// Self-checking bench for sb_tx_msg_arbiter: table-driven single transactions plus hand sequences,
// with completions compared against a scoreboard queue filled when requests are raised.
module tb_sb_tx_msg_arbiter;
    logic clk;
    logic rst;

    sb_tx_msg_arbiter_if #(.SB_MSG_WIDTH(4), .NUM_REQ(4)) bus ();

    sb_tx_msg_arbiter #(.SB_MSG_WIDTH(4), .NUM_REQ(4), .ACK_TIMEOUT(15)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] src;
        logic [3:0] msg;
        logic       to;
    } exp_t;

    typedef struct {
        int         req;
        logic [3:0] msg;
        bit         accept;
        int         delay;
        int         hold;
        int         exp_valid;
        bit         exp_to;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[5];
    int          n_cmp;
    int          n_err;
    int          cyc;
    int          last_done_cyc;
    int          done_gap;
    int          valid_run;
    logic [3:0]  req_valid;
    logic [15:0] req_msg;
    logic [3:0]  rearm;
    logic [3:0]  prev_done;
    bit          ser_accept;
    bit          ser_busy;
    bit          ext_busy;
    int          ser_delay;
    int          ser_hold;
    int          val_cnt;
    int          hold_cnt;
    bit          watch_en;
    logic [3:0]  watch_msg;
    int          watch_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.i_req_valid = req_valid;
        bus.i_req_msg   = req_msg;
        bus.i_sb_busy   = ser_busy | ext_busy;
    endtask

    task automatic push(input int src, input logic [3:0] msg, input bit to);
        exp_t e;
        e.src = 2'(src);
        e.msg = msg;
        e.to  = to;
        sb_q.push_back(e);
    endtask

    // One clock: requester drop, serializer model, monitors and scoreboard compare.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 4; k++) begin
            if (prev_done[k]) req_valid[k] = rearm[k];
        end
        prev_done = bus.o_done;
        if (ser_busy) begin
            hold_cnt++;
            if (hold_cnt >= ser_hold) ser_busy = 1'b0;
        end else if (ser_accept && bus.o_sb_valid) begin
            if (val_cnt >= ser_delay) begin
                ser_busy = 1'b1;
                hold_cnt = 0;
                val_cnt  = 0;
            end else begin
                val_cnt++;
            end
        end else begin
            val_cnt = 0;
        end
        drive();
        if (bus.o_sb_valid) valid_run++;
        if (watch_en && bus.o_sb_msg !== watch_msg) watch_bad++;
        if (bus.o_grant != 4'b0000) begin
            check("grant_onehot", 32'($onehot(bus.o_grant)), 32'd1);
            check("grant_vs_src", 32'(bus.o_grant), 32'(4'b0001 << bus.o_sb_src));
        end
        if (bus.o_done != 4'b0000) begin
            done_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(bus.o_done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_vec", 32'(bus.o_done), 32'(4'b0001 << e.src));
                check("done_src", 32'(bus.o_sb_src), 32'(e.src));
                check("done_msg", 32'(bus.o_sb_msg), 32'(e.msg));
                check("done_timeout", 32'(bus.o_timeout), 32'(e.to));
                check("done_grant_clr", 32'(bus.o_grant), 32'd0);
            end
        end
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (sb_q.size() > 0 && b > 0) begin
            step();
            b--;
        end
        check("drain_budget_left", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.o_sb_valid), 32'd0);
        check({tag, "_msg"}, 32'(bus.o_sb_msg), 32'd0);
        check({tag, "_src"}, 32'(bus.o_sb_src), 32'd0);
        check({tag, "_grant"}, 32'(bus.o_grant), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_timeout"}, 32'(bus.o_timeout), 32'd0);
    endtask

    initial begin
        int dones;
        int bad;
        n_cmp = 0; n_err = 0; cyc = 0; last_done_cyc = 0; done_gap = 0; valid_run = 0;
        req_valid = 4'b0000; req_msg = 16'h0000; rearm = 4'b0000; prev_done = 4'b0000;
        ser_accept = 1'b1; ser_busy = 1'b0; ext_busy = 1'b0; ser_delay = 0; ser_hold = 1;
        val_cnt = 0; hold_cnt = 0; watch_en = 1'b0; watch_msg = 4'h0; watch_bad = 0;
        rst = 1'b1;
        drive();

        vecs[0] = '{1, 4'd3,  1'b1, 2,  5, 3,  1'b0};
        vecs[1] = '{2, 4'd1,  1'b0, 0,  0, 15, 1'b1};
        vecs[2] = '{0, 4'd9,  1'b1, 0,  1, 1,  1'b0};
        vecs[3] = '{3, 4'd15, 1'b1, 5,  2, 6,  1'b0};
        vecs[4] = '{1, 4'd6,  1'b1, 14, 1, 15, 1'b0};

        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Round-robin from ptr 0 with requesters 0, 2, 3 continuously valid
        req_msg   = 16'h3201;
        rearm     = 4'b1101;
        req_valid = 4'b1101;
        ser_accept = 1'b1; ser_delay = 0; ser_hold = 1;
        push(0, 4'h1, 1'b0); push(2, 4'h2, 1'b0); push(3, 4'h3, 1'b0);
        push(0, 4'h1, 1'b0); push(2, 4'h2, 1'b0); push(3, 4'h3, 1'b0);
        drive();
        dones = 0;
        for (int t = 0; t < 80 && dones < 6; t++) begin
            step();
            if (bus.o_done != 4'b0000) begin
                dones++;
                if (dones > 1) check("rr_cycles_per_msg", 32'(done_gap), 32'd4);
                if (dones == 4) rearm = 4'b0000;
            end
        end
        check("rr_done_count", 32'(dones), 32'd6);
        drain(20);
        step();
        step();
        check("rr_idle_after", 32'(bus.o_grant), 32'd0);

        // Table-driven single transactions
        for (int v = 0; v < 5; v++) begin
            valid_run  = 0;
            ser_accept = vecs[v].accept;
            ser_delay  = vecs[v].delay;
            ser_hold   = vecs[v].hold;
            rearm      = 4'b0000;
            req_msg[vecs[v].req*4 +: 4] = vecs[v].msg;
            req_valid[vecs[v].req]      = 1'b1;
            push(vecs[v].req, vecs[v].msg, vecs[v].exp_to);
            drive();
            step();
            check("vec_grant_latency", 32'(bus.o_sb_valid), 32'd1);
            check("vec_grant", 32'(bus.o_grant), 32'(4'b0001 << vecs[v].req));
            check("vec_msg", 32'(bus.o_sb_msg), 32'(vecs[v].msg));
            drain(60);
            check("vec_valid_cycles", 32'(valid_run), 32'(vecs[v].exp_valid));
            step();
            check("vec_done_one_cycle", 32'(bus.o_done), 32'd0);
            step();
        end

        // Timeout on requester 2 must move the pointer to 3
        ser_accept = 1'b0;
        req_msg[8 +: 4] = 4'h1;
        req_valid[2]    = 1'b1;
        push(2, 4'h1, 1'b1);
        drive();
        drain(40);
        step();
        step();
        ser_accept = 1'b1; ser_delay = 0; ser_hold = 1;
        req_msg[0 +: 4]  = 4'h7;
        req_msg[12 +: 4] = 4'hC;
        req_valid = 4'b1001;
        push(3, 4'hC, 1'b0);
        push(0, 4'h7, 1'b0);
        drive();
        drain(40);
        step();
        step();

        // External busy blocks any grant
        ext_busy = 1'b1;
        req_msg[0 +: 4] = 4'h4;
        req_valid[0]    = 1'b1;
        push(0, 4'h4, 1'b0);
        drive();
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (bus.o_grant != 4'b0000 || bus.o_sb_valid) bad++;
        end
        check("ext_busy_no_grant", 32'(bad), 32'd0);
        ext_busy = 1'b0;
        drive();
        step();
        check("ext_busy_release_valid", 32'(bus.o_sb_valid), 32'd1);
        check("ext_busy_release_grant", 32'(bus.o_grant), 32'd1);
        drain(20);
        step();
        step();

        // Reset during WAIT_DONE abandons the transaction and zeroes the pointer
        ser_delay = 0; ser_hold = 10;
        req_msg[8 +: 4] = 4'hB;
        req_valid[2]    = 1'b1;
        drive();
        step();
        step();
        check("midrst_in_wait_valid", 32'(bus.o_sb_valid), 32'd0);
        check("midrst_in_wait_grant", 32'(bus.o_grant), 32'b0100);
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        ser_busy = 1'b0; ser_hold = 1;
        req_msg   = 16'h3218;
        req_valid = 4'b1110;
        push(1, 4'h1, 1'b0); push(2, 4'h2, 1'b0); push(3, 4'h3, 1'b0);
        drive();
        drain(40);
        step();
        step();

        // Committed transaction: requester 3 drops valid and changes msg during ISSUE
        ser_delay = 3; ser_hold = 2;
        req_msg[12 +: 4] = 4'h5;
        req_valid[3]     = 1'b1;
        push(3, 4'h5, 1'b0);
        drive();
        step();
        check("commit_latched_msg", 32'(bus.o_sb_msg), 32'h5);
        req_valid[3]     = 1'b0;
        req_msg[12 +: 4] = 4'hA;
        watch_en  = 1'b1;
        watch_msg = 4'h5;
        watch_bad = 0;
        drive();
        drain(40);
        step();
        step();
        watch_en = 1'b0;
        check("commit_msg_stable", 32'(watch_bad), 32'd0);
        check("commit_msg_kept_idle", 32'(bus.o_sb_msg), 32'h5);
        check("commit_src_kept_idle", 32'(bus.o_sb_src), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
